// File: rtl/algo_1r1w_bank_mem_model_pkg.sv
// Shared types for the banked 1R1W memory model.
// Optional feature macro used by the model: MEM_COLLISION_CHK_EN.
package algo_mem_model_pkg;

  typedef enum logic {
    INIT,
    READY
  } mm_state_t;

  localparam int unsigned MM_MIN_DELAY = 1;

endpackage

// File: rtl/algo_1r1w_bank_mem_model_if.sv
// Banked physical-memory bus: algo top (master) drives, memory model (slave) responds.
interface algo_1r1w_bank_mem_model_if #(
  parameter int unsigned NUMVBNK = 4,
  parameter int unsigned BITSROW = 10,
  parameter int unsigned PHYWDTH = 64
);

  logic                         ready;
  logic [NUMVBNK-1:0]           writeA;
  logic [NUMVBNK*BITSROW-1:0]   addrA;
  logic [NUMVBNK*PHYWDTH-1:0]   bwA;
  logic [NUMVBNK*PHYWDTH-1:0]   dinA;
  logic [NUMVBNK-1:0]           readB;
  logic [NUMVBNK*BITSROW-1:0]   addrB;
  logic [NUMVBNK*PHYWDTH-1:0]   doutB;
  logic [NUMVBNK-1:0]           collide;

  modport master (
    input  ready, doutB, collide,
    output writeA, addrA, bwA, dinA, readB, addrB
  );

  modport slave (
    output ready, doutB, collide,
    input  writeA, addrA, bwA, dinA, readB, addrB
  );

endinterface

// File: rtl/algo_1r1w_bank_mem_model_rd_pipe.sv
// Per-bank read-return pipeline: DELAY cycles from read strobe to held doutB/collide.
module algo_bank_rd_pipe #(
  parameter int unsigned PHYWDTH = 64,
  parameter int unsigned DELAY   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inVld,
  input  logic [PHYWDTH-1:0] inData,
  input  logic               inColl,
  output logic [PHYWDTH-1:0] dout,
  output logic               coll
);

  typedef struct packed {
    logic               vld;
    logic [PHYWDTH-1:0] data;
    logic               coll;
  } rd_stage_t;

  rd_stage_t stIn;
  rd_stage_t stOut;

  assign stIn = '{vld: inVld, data: inData, coll: inColl};

  // The held output register is the last of the DELAY stages, so only DELAY-1 shift stages precede it.
  generate
    if (DELAY > 1) begin : gShift
      rd_stage_t sr [DELAY-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < DELAY-1; i++) begin
            sr[i] <= '0;
          end
        end else begin
          sr[0] <= stIn;
          for (int unsigned i = 1; i < DELAY-1; i++) begin
            sr[i] <= sr[i-1];
          end
        end
      end

      assign stOut = sr[DELAY-2];
    end else begin : gDirect
      assign stOut = stIn;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      coll <= 1'b0;
    end else begin
      if (stOut.vld) begin
        dout <= stOut.data;
      end
      coll <= stOut.vld & stOut.coll;
    end
  end

endmodule

// File: rtl/algo_1r1w_bank_mem_model.sv
// Banked 1R1W memory model with self-initialisation and fixed read latency.
// Define MEM_COLLISION_CHK_EN to flag same-row read/write collisions on collide.
module algo_1r1w_bank_mem_model
  import algo_mem_model_pkg::*;
#(
  parameter int unsigned        NUMVBNK = 4,
  parameter int unsigned        NUMSROW = 1024,
  parameter int unsigned        BITSROW = 10,
  parameter int unsigned        PHYWDTH = 64,
  parameter int unsigned        DELAY   = 1,
  parameter logic [PHYWDTH-1:0] INITVAL = '0
) (
  input logic                        clk,
  input logic                        rst,
  algo_1r1w_bank_mem_model_if.slave  memIf
);

  mm_state_t                       state;
  logic [BITSROW-1:0]              initCnt;
  logic                            readyR;
  logic [NUMVBNK-1:0][PHYWDTH-1:0] doutArr;
  logic [NUMVBNK-1:0]              collArr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      initCnt <= '0;
      readyR  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          initCnt <= initCnt + 1'b1;
          if (initCnt == BITSROW'(NUMSROW-1)) begin
            state  <= READY;
            readyR <= 1'b1;
          end
        end
        READY: begin
          readyR <= 1'b1;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  assign memIf.ready   = readyR;
  assign memIf.doutB   = doutArr;
  assign memIf.collide = collArr;

  for (genvar b = 0; b < NUMVBNK; b++) begin : gBank
    logic [PHYWDTH-1:0] mem [NUMSROW];
    logic [BITSROW-1:0] wAddr;
    logic [BITSROW-1:0] rAddr;
    logic [PHYWDTH-1:0] bw;
    logic [PHYWDTH-1:0] din;
    logic               rdVld;
    logic               rdColl;

    assign wAddr = memIf.addrA[b*BITSROW +: BITSROW];
    assign rAddr = memIf.addrB[b*BITSROW +: BITSROW];
    assign bw    = memIf.bwA[b*PHYWDTH +: PHYWDTH];
    assign din   = memIf.dinA[b*PHYWDTH +: PHYWDTH];
    assign rdVld = memIf.readB[b] && (state == READY);

    // Init owns the write port; external writes are dropped until READY.
    always_ff @(posedge clk) begin
      if (!rst) begin
        if (state == INIT) begin
          mem[initCnt] <= INITVAL;
        end else if (memIf.writeA[b]) begin
          mem[wAddr] <= (mem[wAddr] & ~bw) | (din & bw);
        end
      end
    end

`ifdef MEM_COLLISION_CHK_EN
    assign rdColl = rdVld && memIf.writeA[b] && (wAddr == rAddr);

    always_ff @(posedge clk) begin
      if (!rst && rdColl) begin
        $display("algo_1r1w_bank_mem_model: R/W collision bank %0d row %0d time %0t",
                 b, rAddr, $time);
      end
    end
`else
    assign rdColl = 1'b0;
`endif

    // mem is read before the same-edge write lands, giving read-before-write.
    algo_bank_rd_pipe #(
      .PHYWDTH (PHYWDTH),
      .DELAY   (DELAY)
    ) uRdPipe (
      .clk    (clk),
      .rst    (rst),
      .inVld  (rdVld),
      .inData (mem[rAddr]),
      .inColl (rdColl),
      .dout   (doutArr[b]),
      .coll   (collArr[b])
    );
  end

endmodule

// File: tb/tb_algo_1r1w_bank_mem_model.sv
// Scoreboard bench for algo_1r1w_bank_mem_model: stimulus pushes expected returns, a monitor checks them.
module tb_algo_1r1w_bank_mem_model;

  localparam int unsigned        NB  = 4;
  localparam int unsigned        NR  = 1024;
  localparam int unsigned        BR  = 10;
  localparam int unsigned        PW  = 64;
  localparam int unsigned        DLY = 3;
  localparam logic [PW-1:0]      IV  = '0;

  typedef struct {
    int unsigned   due;
    logic [PW-1:0] data;
    bit            coll;
  } exp_t;

  logic clk;
  logic rst;

  algo_1r1w_bank_mem_model_if #(.NUMVBNK(NB), .BITSROW(BR), .PHYWDTH(PW)) busIf ();

  algo_1r1w_bank_mem_model #(
    .NUMVBNK (NB),
    .NUMSROW (NR),
    .BITSROW (BR),
    .PHYWDTH (PW),
    .DELAY   (DLY),
    .INITVAL (IV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .memIf (busIf.slave)
  );

  logic [PW-1:0] modelMem [NB][NR];
  logic [PW-1:0] held [NB];
  exp_t          expQ [NB][$];
  int unsigned   cyc     = 0;
  int unsigned   lastRst = 0;
  bit            rstSeen = 0;
  int unsigned   checks  = 0;
  int unsigned   errors  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit modelReady();
    return rstSeen && (cyc >= lastRst + NR);
  endfunction

  // Reference: reset wipes contents to INITVAL and discards everything in flight.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        rstSeen = 1;
        lastRst = cyc;
        for (int b = 0; b < NB; b++) begin
          expQ[b].delete();
          held[b] = '0;
          for (int r = 0; r < NR; r++) modelMem[b][r] = IV;
        end
      end
    end
  end

  initial begin
    exp_t e;
    bit   expColl;
    forever begin
      @(negedge clk);
      if (rstSeen) begin
        checks++;
        if (busIf.ready !== modelReady()) begin
          errors++;
          $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, busIf.ready, modelReady());
        end
        for (int b = 0; b < NB; b++) begin
          expColl = 0;
          if (expQ[b].size() > 0 && expQ[b][0].due <= cyc) begin
            e = expQ[b].pop_front();
            held[b] = e.data;
            expColl = e.coll;
          end
`ifndef MEM_COLLISION_CHK_EN
          expColl = 0;
`endif
          checks++;
          if (busIf.doutB[b*PW +: PW] !== held[b]) begin
            errors++;
            $display("FAIL doutB bank=%0d cyc=%0d got=%h exp=%h", b, cyc, busIf.doutB[b*PW +: PW], held[b]);
          end
          checks++;
          if (busIf.collide[b] !== expColl) begin
            errors++;
            $display("FAIL collide bank=%0d cyc=%0d got=%b exp=%b", b, cyc, busIf.collide[b], expColl);
          end
        end
      end
    end
  end

  task automatic clearIn();
    busIf.writeA = '0;
    busIf.readB  = '0;
    busIf.addrA  = '0;
    busIf.addrB  = '0;
    busIf.bwA    = '0;
    busIf.dinA   = '0;
  endtask

  task automatic setW(input int b, input int unsigned row, input logic [PW-1:0] d, input logic [PW-1:0] m);
    busIf.writeA[b]          = 1'b1;
    busIf.addrA[b*BR +: BR]  = BR'(row);
    busIf.dinA[b*PW +: PW]   = d;
    busIf.bwA[b*PW +: PW]    = m;
  endtask

  task automatic setR(input int b, input int unsigned row);
    busIf.readB[b]          = 1'b1;
    busIf.addrB[b*BR +: BR] = BR'(row);
  endtask

  // Record what the driven cycle should do, then let it be sampled.
  task automatic step();
    logic [BR-1:0] ra;
    logic [BR-1:0] wa;
    logic [PW-1:0] m;
    if (!rst && modelReady()) begin
      for (int b = 0; b < NB; b++) begin
        ra = busIf.addrB[b*BR +: BR];
        wa = busIf.addrA[b*BR +: BR];
        if (busIf.readB[b])
          expQ[b].push_back('{due: cyc + DLY, data: modelMem[b][ra],
                              coll: busIf.writeA[b] && (wa == ra)});
        if (busIf.writeA[b]) begin
          m = busIf.bwA[b*PW +: PW];
          modelMem[b][wa] = (modelMem[b][wa] & ~m) | (busIf.dinA[b*PW +: PW] & m);
        end
      end
    end
    @(posedge clk);
    #1;
    clearIn();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [PW-1:0] pat;
    rst = 1'b1;
    clearIn();
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;

    // Reads and writes during init are dropped.
    setR(0, 5);
    setW(0, 5, {PW{1'b1}}, {PW{1'b1}});
    step();
    idle(NR + 2);

    setR(0, 5);
    step();
    pat = {16{4'hA, 4'h5}};
    setW(2, 10'h3FF, pat, {PW{1'b1}});
    step();
    setR(2, 10'h3FF);
    setR(0, 10'h3FF);
    step();

    for (int b = 0; b < NB; b++) setW(b, 0, {PW{1'b1}}, 64'h0000_0000_FFFF_FFFF);
    step();
    for (int b = 0; b < NB; b++) setR(b, 0);
    step();

    setW(1, 7, 64'h1, {PW{1'b1}});
    setR(1, 7);
    step();
    setR(1, 7);
    step();
    idle(DLY + 1);

    setW(3, 1, 64'd11, {PW{1'b1}});
    step();
    setW(3, 2, 64'd22, {PW{1'b1}});
    step();
    setW(3, 3, 64'd33, {PW{1'b1}});
    step();
    setR(3, 1);
    step();
    setR(3, 2);
    step();
    setR(3, 3);
    step();
    idle(DLY + 4);

    // Narrow row range forces frequent same-row collisions and partial-mask merges.
    for (int unsigned i = 0; i < 400; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 1) == 1)
          setW(b, $urandom_range(0, 15), {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? {PW{1'b1}} : {$urandom, $urandom});
        if ($urandom_range(0, 1) == 1)
          setR(b, $urandom_range(0, 15));
      end
      step();
    end
    idle(DLY + 2);

    setR(0, 5);
    step();
    setR(2, 10'h3FF);
    step();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(NR + 2);
    setR(2, 10'h3FF);
    setR(1, 7);
    step();
    idle(DLY + 3);

    for (int b = 0; b < NB; b++) begin
      checks++;
      if (expQ[b].size() != 0) begin
        errors++;
        $display("FAIL drain bank=%0d got=%0d pending exp=0", b, expQ[b].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
